// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary to packed BCD converter.
// One BCD iteration per clock, start/out_valid/out_ack handshake.
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   start       in   conversion request (IDLE, or DONE with out_ack)
//   binary      in   operand, captured when start is accepted
//   is_signed   in   two's-complement operand (only when SIGNED_EN=1)
//   busy        out  conversion in progress
//   out_valid   out  result held until out_ack
//   out_ack     in   consumer takes the result
//   bcd         out  packed BCD, digit 0 in bits [3:0]
//   negative    out  operand was negative
//   num_digits  out  most significant nonzero digit index + 1 (min 1)
module bin_to_bcd_seq #(
  parameter int BIN_W     = 12,
  parameter int DIGITS    = 4,
  parameter int SIGNED_EN = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [BIN_W-1:0]             binary,
  input  logic                         is_signed,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ack,
  output logic [4*DIGITS-1:0]          bcd,
  output logic                         negative,
  output logic [$clog2(DIGITS+1)-1:0]  num_digits
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int FW    = BCD_W + BIN_W;
  localparam int CW    = $clog2(BIN_W + 1);
  localparam int NDW   = $clog2(DIGITS + 1);

  // Largest magnitude must fit in DIGITS decimal digits.
  function automatic bit range_ok();
    longint unsigned p;
    longint unsigned m;
    p = 64'd1;
    for (int i = 0; i < DIGITS && i < 19; i++)
      p = p * 64'd10;
    if (SIGNED_EN != 0)
      m = 64'd1 << (BIN_W - 1);
    else
      m = (64'd1 << BIN_W) - 64'd1;
    return (DIGITS >= 19) || (p > m);
  endfunction

  localparam bit RANGE_OK = range_ok();

  if (BIN_W < 2) begin : g_bad_width
    $error("bin_to_bcd_seq: BIN_W must be >= 2");
  end

  if (!RANGE_OK) begin : g_bad_range
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [FW-1:0]    field;
  logic [CW-1:0]    cnt;
  logic             neg_r;

  logic             accept;
  logic             load_neg;
  logic [BIN_W-1:0] load_mag;
  logic [FW-1:0]    adj;
  logic [FW-1:0]    shifted;
  logic [BCD_W-1:0] fin_bcd;
  logic [NDW-1:0]   fin_nd;

  assign busy = (state == S_SHIFT);

  assign accept = start &&
    ((state == S_IDLE) || ((state == S_DONE) && out_ack));

  // Negating the most negative value yields 2^(BIN_W-1),
  // which still fits as an unsigned BIN_W-bit magnitude.
  assign load_neg = (SIGNED_EN != 0) && is_signed &&
                    binary[BIN_W-1];
  assign load_mag = load_neg ? (~binary + BIN_W'(1)) : binary;

  // Add-3 on the pre-shift digits, then shift as one update.
  always_comb begin
    adj = field;
    for (int i = 0; i < DIGITS; i++) begin
      if (field[BIN_W+4*i +: 4] >= 4'd5)
        adj[BIN_W+4*i +: 4] = field[BIN_W+4*i +: 4] + 4'd3;
    end
    shifted = adj << 1;
  end

  assign fin_bcd = shifted[FW-1:BIN_W];

  always_comb begin
    fin_nd = NDW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (fin_bcd[4*i +: 4] != 4'd0)
        fin_nd = NDW'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      field      <= '0;
      cnt        <= '0;
      neg_r      <= 1'b0;
      out_valid  <= 1'b0;
      bcd        <= '0;
      negative   <= 1'b0;
      num_digits <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            field <= {{BCD_W{1'b0}}, load_mag};
            neg_r <= load_neg;
            cnt   <= CW'(BIN_W);
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          field <= shifted;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd        <= fin_bcd;
            negative   <= neg_r;
            num_digits <= fin_nd;
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ack) begin
            out_valid <= 1'b0;
            if (start) begin
              field <= {{BCD_W{1'b0}}, load_mag};
              neg_r <= load_neg;
              cnt   <= CW'(BIN_W);
              state <= S_SHIFT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Parametrised, sequential double-dabble converter. It is the successor to the fixed 12-bit/4-digit converter and feeds the seven-segment and display-formatting logic.
- Converts a BIN_W-bit operand, optionally two's-complement, into DIGITS packed BCD digits, with a sign flag and a significant-digit count for leading-zero blanking.
- Uses a start / out_valid / out_ack handshake, and supports back-to-back conversions.

Parameters:
- BIN_W, 12, operand width in bits (>= 2).
- DIGITS, 4, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1 in unsigned mode, or > 2^(BIN_W-1) in signed mode. A violation is an elaboration-time $error.
- SIGNED_EN, 0, set to 1 to enable two's-complement interpretation via the is_signed input.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a conversion. Sampled only in IDLE, or in DONE together with out_ack.
- binary  in  BIN_W  operand, captured on the edge that accepts start.
- is_signed  in  1  treat binary as two's complement. Ignored when SIGNED_EN=0.
- busy  out  1  high while in SHIFT.
- out_valid  out  1  result available. Held until acknowledged.
- out_ack  in  1  consumer accepts the result.
- bcd  out  4*DIGITS  packed BCD, digit 0 at bits [3:0].
- negative  out  1  operand was negative (signed mode only).
- num_digits  out  $clog2(DIGITS+1)  index of the most significant nonzero digit plus 1. Minimum 1 (value 0 reports 1).

Behaviour:
- Reset (reset_n low, asynchronous):
  - state goes to IDLE.
  - busy, out_valid, bcd, negative and num_digits all become 0.
  - Internal shift register and counter are cleared.
  - Applies equally mid-conversion; the partial result is discarded.
- States: IDLE, SHIFT, DONE. Encoding is free.
- IDLE:
  - busy=0, out_valid=0.
  - On an edge with start=1: magnitude=binary, or its two's-complement negation when SIGNED_EN & is_signed & binary[BIN_W-1].
  - neg_r is set to that condition. BCD field is cleared. counter=BIN_W. Go to SHIFT.
- SHIFT, one iteration per edge:
  - Every digit >= 5 gets +3 (all digits evaluated on the pre-shift value).
  - Then the combined {bcd, magnitude} field shifts left by 1 and counter decrements.
  - The add-3 and the shift are a single combined update, not two competing nonblocking assignments.
  - On the edge where counter==1: register bcd, negative=neg_r, num_digits. Set out_valid=1 and go to DONE.
  - start is ignored in SHIFT.
- Latency: start accepted at edge 0; out_valid rises after edge BIN_W (12 cycles at the default).
- DONE:
  - out_valid=1. bcd, negative and num_digits are held stable until out_ack.
  - out_ack=1, start=0: out_valid goes to 0 and the state returns to IDLE. Outputs keep their last values.
  - out_ack=1, start=1: the new operand is loaded exactly as in IDLE, out_valid goes to 0, and the state goes to SHIFT (back-to-back conversion, no idle cycle).
  - out_ack=0: start is ignored.
- Width rules:
  - Negating -2^(BIN_W-1) gives 2^(BIN_W-1), which is representable in BIN_W unsigned bits; no overflow.
  - The internal field is 4*DIGITS+BIN_W bits wide.
- negative is always 0 when SIGNED_EN=0, or when is_signed=0.

Test Plan:
- BIN_W=12, DIGITS=4, binary=4095, start pulse:
  - busy for 12 cycles; out_valid after edge 12.
  - bcd=0x4095, num_digits=4, negative=0.
- binary=0 -> bcd=0x0000, num_digits=1. binary=9 -> bcd=0x0009, num_digits=1. binary=10 -> bcd=0x0010, num_digits=2.
- SIGNED_EN=1, BIN_W=8, DIGITS=3, is_signed=1:
  - 0x80 -> bcd=0x128, negative=1, num_digits=3.
  - 0xFF -> bcd=0x001, negative=1.
  - 0x7F -> bcd=0x127, negative=0.
  - With is_signed=0, 0xFF -> bcd=0x255, negative=0.
- Handshake and back-to-back:
  - Hold out_ack=0 for 5 cycles: outputs stable, out_valid=1, a start pulse is ignored.
  - Then out_ack=1 with start=1 and binary=123: out_valid drops next cycle, busy=1, bcd=0x0123 after 12 more edges.
- Assert start during SHIFT with a different operand: it is ignored, and the original result is produced.
- Drive reset_n low at SHIFT iteration 6, asynchronously between edges:
  - All outputs go to 0 immediately.
  - After release, a fresh start with 2024 yields bcd=0x2024.
